// File: rtl/seg_pkg.sv
// Shared constants, state type and digit helper for the two-digit
// multiplexed 7-segment scan driver.
package seg_pkg;

   localparam int DIGIT_W = 7;
   localparam int DIGIT_N = 2;

   localparam logic [DIGIT_W-1:0] SEG_BLANK = 7'h7F;
   localparam logic [DIGIT_W-1:0] SEG_E     = 7'b0000110;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_SHOW  = 1'b1
   } scan_state_e;

   function automatic logic [DIGIT_W-1:0] digit_of(
      input logic [DIGIT_N*DIGIT_W-1:0] codes,
      input logic                       sel
   );
      logic [DIGIT_W-1:0] d;
      if (sel) begin
         d = codes[2*DIGIT_W-1:DIGIT_W];
      end else begin
         d = codes[DIGIT_W-1:0];
      end
      return d;
   endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Digit-slot prescaler: free-running 0..CLK_DIV-1 counter with a
// terminal-count tick.
module seg_prescaler #(
   parameter int CLK_DIV = 50000,
   localparam int CW = $clog2(CLK_DIV)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          tick,
   output logic [CW-1:0] cnt
);

   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Wrap at the terminal count, otherwise advance.
   always_comb begin
      cnt_d = cnt_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == CNT_LAST);
   assign cnt  = cnt_q;

endmodule

// File: rtl/seg_scan_chk.sv
// Run-time checks on the anode drive: never two digits on at once,
// and all anodes off during the blanking interval.
module seg_scan_chk (
   input logic       clk,
   input logic       rst_n,
   input logic [1:0] an,
   input logic       blank
);

   a_no_double_anode: assert property (@(posedge clk) disable iff (!rst_n)
      an != 2'b00);

   a_blank_anodes_off: assert property (@(posedge clk) disable iff (!rst_n)
      blank |-> (an == 2'b11));

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit multiplexed 7-segment driver with anti-ghost blanking and a
// blinking "E" indication for adder errors.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYC    = 500,
   parameter int BLINK_FRAMES = 25
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [13:0] seg_in,
   input  logic        err_in,
   input  logic        load,
   output logic [6:0]  seg_out,
   output logic [1:0]  an_out,
   output logic        frame_done
);

   localparam int CW = $clog2(CLK_DIV);
   localparam int BW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [BW-1:0] BLINK_ONE  = BW'(1);

   logic          tick_s;
   logic [CW-1:0] cnt_s;
   logic          frame_done_s;

   scan_state_e   state_q, state_d;
   logic          sel_q, sel_d;
   logic [13:0]   seg_q, seg_d;
   logic          err_q, err_d;
   logic          blink_on_q, blink_on_d;
   logic [BW-1:0] bcnt_q, bcnt_d;

   seg_prescaler #(.CLK_DIV(CLK_DIV)) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_s),
      .cnt   (cnt_s)
   );

   assign frame_done_s = tick_s & sel_q;

   // Next-state: slot FSM, digit select, capture and blink phase.
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      seg_d      = seg_q;
      err_d      = err_q;
      blink_on_d = blink_on_q;
      bcnt_d     = bcnt_q;

      case (state_q)
         ST_BLANK: if (cnt_s == BLANK_LAST) state_d = ST_SHOW; else state_d = ST_BLANK;
         ST_SHOW:  if (tick_s) state_d = ST_BLANK; else state_d = ST_SHOW;
         default:  state_d = ST_BLANK;
      endcase

      if (tick_s) begin
         sel_d = ~sel_q;
      end else begin
         sel_d = sel_q;
      end

      if (load) begin
         seg_d = seg_in;
         err_d = err_in;
      end else begin
         seg_d = seg_q;
         err_d = err_q;
      end

      // Idle counter while error-free so each new error opens lit.
      if (!err_q) begin
         bcnt_d     = '0;
         blink_on_d = 1'b1;
      end else if (frame_done_s) begin
         if (bcnt_q == BLINK_LAST) begin
            bcnt_d     = '0;
            blink_on_d = ~blink_on_q;
         end else begin
            bcnt_d     = bcnt_q + BLINK_ONE;
         end
      end else begin
         bcnt_d = bcnt_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_BLANK;
         sel_q      <= 1'b0;
         seg_q      <= 14'h3FFF;
         err_q      <= 1'b0;
         blink_on_q <= 1'b1;
         bcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         err_q      <= err_d;
         blink_on_q <= blink_on_d;
         bcnt_q     <= bcnt_d;
      end
   end

   // Output decode from registered state only.
   always_comb begin
      seg_out = SEG_BLANK;
      an_out  = 2'b11;
      if ((state_q == ST_SHOW) && (!err_q || blink_on_q)) begin
         an_out = sel_q ? 2'b01 : 2'b10;
         if (err_q) begin
            seg_out = SEG_E;
         end else begin
            seg_out = digit_of(seg_q, sel_q);
         end
      end else begin
         seg_out = SEG_BLANK;
         an_out  = 2'b11;
      end
   end

   assign frame_done = frame_done_s;

   seg_scan_chk u_chk (
      .clk   (clk),
      .rst_n (rst_n),
      .an    (an_out),
      .blank (state_q == ST_BLANK)
   );

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench: a cycle-indexed reference model pushes expected
// {frame_done, an_out, seg_out}; a negedge monitor pops and compares.
module tb_seg_scan_driver;

   localparam int CD = 8;
   localparam int BC = 2;
   localparam int BF = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [13:0] seg_in;
   logic        err_in;
   logic        load;
   logic [6:0]  seg_out;
   logic [1:0]  an_out;
   logic        frame_done;

   seg_scan_driver #(.CLK_DIV(CD), .BLANK_CYC(BC), .BLINK_FRAMES(BF)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .seg_in     (seg_in),
      .err_in     (err_in),
      .load       (load),
      .seg_out    (seg_out),
      .an_out     (an_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         t;
      logic [9:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // Reference model: cycles since reset release plus captured data.
   int          t;
   logic [13:0] mseg;
   logic        merr;
   int          err_frames;

   task automatic chk(input string name, input int tt, input logic [9:0] got, input logic [9:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0d: got fd/an/seg=%b/%b/%h expected %b/%b/%h",
                  name, tt, got[9], got[8:7], got[6:0], exp[9], exp[8:7], exp[6:0]);
      end
   endtask

   function automatic logic [9:0] model_out();
      int         pos;
      int         sel;
      bit         lit;
      logic [6:0] s;
      logic [1:0] a;
      logic       fd;
      pos = t % CD;
      sel = (t / CD) % 2;
      lit = ((err_frames / BF) % 2) == 0;
      fd  = (pos == CD - 1) && (sel == 1);
      if (pos < BC || (merr && !lit)) begin
         a = 2'b11;
         s = 7'h7F;
      end else begin
         a = (sel == 1) ? 2'b01 : 2'b10;
         if (merr)          s = 7'b0000110;
         else if (sel == 1) s = mseg[13:7];
         else               s = mseg[6:0];
      end
      return {fd, a, s};
   endfunction

   task automatic push_expected();
      exp_t e;
      e.t = t;
      e.v = model_out();
      exp_q.push_back(e);
   endtask

   task automatic model_reset();
      t          = 0;
      mseg       = 14'h3FFF;
      merr       = 1'b0;
      err_frames = 0;
   endtask

   task automatic model_edge(input logic ld, input logic [13:0] s, input logic e);
      bit fd_prev;
      fd_prev = (t % CD == CD - 1) && ((t / CD) % 2 == 1);
      if (!merr)        err_frames = 0;
      else if (fd_prev) err_frames++;
      if (ld) begin
         mseg = s;
         merr = e;
      end
      t++;
   endtask

   task automatic step(input logic ld, input logic [13:0] s, input logic e);
      load   = ld;
      seg_in = s;
      err_in = e;
      @(posedge clk);
      #1;
      model_edge(ld, s, e);
      push_expected();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 14'h0000, 1'b0);
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      push_expected();
   endtask

   // Monitor: compare whatever the model has queued for this cycle.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("scan", e.t, {frame_done, an_out, seg_out}, e.v);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      load   = 1'b0;
      seg_in = 14'h0000;
      err_in = 1'b0;
      rst_n  = 1'b1;
      model_reset();
      #2 rst_n = 1'b0;
      #1 chk("reset_out", -1, {frame_done, an_out, seg_out}, {1'b0, 2'b11, 7'h7F});
      release_reset();

      // Normal digits, free-running frames.
      step(1'b1, 14'h0F99, 1'b0);
      idle(40);

      // Error blink, then recovery, then a fresh error.
      step(1'b1, 14'(($urandom)), 1'b1);
      idle(8 * 2 * CD);
      step(1'b1, 14'h1234, 1'b0);
      idle(3 * CD);
      step(1'b1, 14'h0ABC, 1'b1);
      idle(6 * 2 * CD);
      step(1'b1, 14'h2A55, 1'b0);
      idle(CD);

      // Loads landing exactly on the tick cycle, and back-to-back loads.
      for (int k = 0; k < 4; k++) begin
         while (t % CD != CD - 1) step(1'b0, 14'h0000, 1'b0);
         step(1'b1, 14'($urandom), 1'b0);
         step(1'b1, 14'($urandom), 1'b0);
         step(1'b1, 14'($urandom), 1'b0);
      end
      idle(2 * CD);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         step($urandom_range(9, 0) == 0, 14'($urandom), $urandom_range(3, 0) == 0);
      end

      // Asynchronous reset mid-slot at cnt=5 while showing a digit.
      step(1'b1, 14'h0F99, 1'b0);
      while (t % CD != 5) step(1'b0, 14'h0000, 1'b0);
      load = 1'b0;
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1 chk("midslot_reset", t, {frame_done, an_out, seg_out}, {1'b0, 2'b11, 7'h7F});
      release_reset();
      idle(40);

      @(negedge clk);
      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
